// File: rtl/dr_pkg.sv
// Dual-rail encoding constants and helpers shared by the NCL sandbox blocks.
// NULL=00, DATA0=01 (false rail), DATA1=10 (true rail); 11 is never produced.
package dr_pkg;

    localparam logic [1:0] DR_NULL  = 2'b00;
    localparam logic [1:0] DR_DATA0 = 2'b01;
    localparam logic [1:0] DR_DATA1 = 2'b10;

    function automatic logic [1:0] drEncode(input logic b);
        return b ? DR_DATA1 : DR_DATA0;
    endfunction

    function automatic logic drDecode(input logic [1:0] r);
        return r[1];
    endfunction

    function automatic logic drIsData(input logic [1:0] r);
        return r[1] | r[0];
    endfunction

endpackage

// File: rtl/dr_count_digit.sv
// One binary digit of the dual-rail counter: absorbs a DATA carry/borrow,
// emits the new digit and the carry/borrow for the next stage one clock later.
module dr_count_digit
    import dr_pkg::*;
#(
    parameter logic INIT_BIT = 1'b0
) (
    input  logic       clk_i,
    input  logic       init_i,
    input  logic       hold_i,
    input  logic [1:0] carry_i,
    input  logic       tag_i,
    output logic [1:0] sum_o,
    output logic [1:0] carry_o,
    output logic       tag_o,
    output logic       value_o
);

    logic       v_q, v_d;
    logic [1:0] sum_q, sum_d;
    logic [1:0] carry_q, carry_d;
    logic       tag_q, tag_d;
    logic       cBit;

    // tag_i selects up (carry = v&c) or down (borrow = ~v&c) for this wavefront
    always_comb begin
        v_d     = v_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        tag_d   = tag_q;
        cBit    = drDecode(carry_i);
        if (!hold_i) begin
            tag_d = tag_i;
            if (drIsData(carry_i)) begin
                v_d     = v_q ^ cBit;
                sum_d   = drEncode(v_q ^ cBit);
                carry_d = drEncode(tag_i ? (~v_q & cBit) : (v_q & cBit));
            end else begin
                sum_d   = DR_NULL;
                carry_d = DR_NULL;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (init_i) begin
            v_q     <= INIT_BIT;
            sum_q   <= DR_NULL;
            carry_q <= DR_NULL;
            tag_q   <= 1'b0;
        end else begin
            v_q     <= v_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            tag_q   <= tag_d;
        end
    end

    assign sum_o   = sum_q;
    assign carry_o = carry_q;
    assign tag_o   = tag_q;
    assign value_o = v_q;

endmodule

// File: rtl/dr_digit_counter_n.sv
// Parametrised dual-rail up/down counter: an injector alternating DATA/NULL
// wavefronts into a chain of digit stages, plus a wavefront-completion pulse.
module dr_digit_counter_n
    import dr_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic               clk,
    input  logic               init,
    input  logic               en,
    input  logic               dn,
    input  logic               hold,
    output logic [2*WIDTH-1:0] sum,
    output logic [WIDTH-1:0]   sum_comp,
    output logic [1:0]         cout,
    output logic               wave_done,
    output logic [WIDTH-1:0]   value
);

    logic                 phase_q, phase_d;
    logic                 waveDone_q, waveDone_d;
    logic [WIDTH:0][1:0]  carryChain;
    logic [WIDTH:0]       tagChain;
    logic                 unusedTopTag;

    // Phase 0 injects the en-selected DATA carry, phase 1 injects NULL
    always_comb begin
        phase_d    = phase_q;
        waveDone_d = waveDone_q;
        if (!hold) begin
            phase_d    = ~phase_q;
            waveDone_d = drIsData(carryChain[WIDTH]);
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            phase_q    <= 1'b0;
            waveDone_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            waveDone_q <= waveDone_d;
        end
    end

    assign carryChain[0] = phase_q ? DR_NULL : drEncode(en);
    assign tagChain[0]   = dn;

    for (genvar i = 0; i < WIDTH; i++) begin : gDigit
        dr_count_digit #(
            .INIT_BIT (INIT_VALUE[i])
        ) uDigit (
            .clk_i    (clk),
            .init_i   (init),
            .hold_i   (hold),
            .carry_i  (carryChain[i]),
            .tag_i    (tagChain[i]),
            .sum_o    (sum[2*i+1 -: 2]),
            .carry_o  (carryChain[i+1]),
            .tag_o    (tagChain[i+1]),
            .value_o  (value[i])
        );
        assign sum_comp[i] = drIsData(sum[2*i+1 -: 2]);
    end

    assign unusedTopTag = tagChain[WIDTH];
    assign cout         = carryChain[WIDTH];
    assign wave_done    = waveDone_q;

endmodule

// File: tb/tb_dr_digit_counter_n.sv
// Scoreboard bench for dr_digit_counter_n (WIDTH=4, INIT_VALUE=5): directed
// wavefronts push expected results; a monitor reassembles digits and compares.
module tb_dr_digit_counter_n;

    localparam int         WIDTH = 4;
    localparam logic [3:0] INIT  = 4'd5;

    typedef struct {
        logic [3:0] val;
        logic [1:0] cout;
        int         doneAt;
    } expT;

    logic               clk = 1'b0;
    logic               init, en, dn, hold;
    logic [2*WIDTH-1:0] sum;
    logic [WIDTH-1:0]   sum_comp;
    logic [1:0]         cout;
    logic               wave_done;
    logic [WIDTH-1:0]   value;

    expT  expQ[$];
    logic digitQ[WIDTH][$];
    int   checks = 0, errors = 0;
    int   waveK = 0, activeEdge = -1, wdPulses = 0, expPulses = 0;
    bit   lastInit = 1'b0, lastActive = 1'b0, prevCoutData = 1'b0;

    logic [3:0] upExp[16]   = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13,
                                4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    logic [3:0] downExp[14] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15, 4'd14,
                                4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8, 4'd7};

    dr_digit_counter_n #(.WIDTH(WIDTH), .INIT_VALUE(INIT)) dut (
        .clk       (clk),
        .init      (init),
        .en        (en),
        .dn        (dn),
        .hold      (hold),
        .sum       (sum),
        .sum_comp  (sum_comp),
        .cout      (cout),
        .wave_done (wave_done),
        .value     (value)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        #1;
    endtask

    // One wavefront spans two non-hold cycles (DATA phase, then NULL phase)
    task automatic applyStimulus(input logic e, input logic d, input logic [3:0] expVal, input logic expC);
        expT x;
        en = e;
        dn = d;
        x.val    = expVal;
        x.cout   = expC ? 2'b10 : 2'b01;
        x.doneAt = 2 * waveK + WIDTH - 1;
        expQ.push_back(x);
        waveK++;
        expPulses++;
        stepCycle();
        stepCycle();
    endtask

    task automatic holdCycles(input int n);
        logic [2*WIDTH-1:0] sSum;
        logic [WIDTH-1:0]   sComp, sVal;
        logic [1:0]         sCout;
        logic               sDone;
        sSum = sum; sComp = sum_comp; sVal = value; sCout = cout; sDone = wave_done;
        hold = 1'b1;
        for (int i = 0; i < n; i++) begin
            stepCycle();
            checkOutput("hold_sum", 32'(sum), 32'(sSum));
            checkOutput("hold_sum_comp", 32'(sum_comp), 32'(sComp));
            checkOutput("hold_value", 32'(value), 32'(sVal));
            checkOutput("hold_cout", 32'(cout), 32'(sCout));
            checkOutput("hold_wave_done", 32'(wave_done), 32'(sDone));
        end
        hold = 1'b0;
    endtask

    always @(posedge clk) begin
        lastInit   = init;
        lastActive = !init && !hold;
        if (init)
            activeEdge = -1;
        else if (!hold)
            activeEdge++;
    end

    // Monitor: collect each digit's DATA in order and score a wavefront when it reaches the top digit
    always @(negedge clk) begin
        logic [3:0] got;
        bit         ok;
        expT        e;
        if (lastInit) begin
            for (int i = 0; i < WIDTH; i++) digitQ[i].delete();
            prevCoutData = 1'b0;
        end else if (lastActive) begin
            checkOutput("wave_done_timing", 32'(wave_done), 32'(prevCoutData));
            if (wave_done) wdPulses++;
            prevCoutData = (cout == 2'b01) || (cout == 2'b10);
            for (int i = 0; i < WIDTH; i++)
                if (sum_comp[i]) digitQ[i].push_back(sum[2*i+1]);
            if (sum_comp[WIDTH-1]) begin
                got = '0;
                ok  = 1'b1;
                for (int i = 0; i < WIDTH; i++) begin
                    if (digitQ[i].size() == 0) ok = 1'b0;
                    else got[i] = digitQ[i].pop_front();
                end
                checkOutput("digit_order", 32'(ok), 32'd1);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_wavefront", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("digits", 32'(got), 32'(e.val));
                    checkOutput("cout", 32'(cout), 32'(e.cout));
                    checkOutput("done_edge", 32'(activeEdge), 32'(e.doneAt));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        init = 1'b1; en = 1'b0; dn = 1'b0; hold = 1'b0;
        repeat (3) stepCycle();
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_sum_comp", 32'(sum_comp), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        checkOutput("reset_wave_done", 32'(wave_done), 32'd0);
        checkOutput("reset_value", 32'(value), 32'(INIT));
        init = 1'b0;

        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, upExp[i], i == 10);
        applyStimulus(1'b0, 1'b0, 4'd5, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd5, 1'b0);
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b1, downExp[i], i == 5);
        applyStimulus(1'b1, 1'b0, 4'd8, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'd7, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd8, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'd7, 1'b0);

        // Two wavefronts in flight when init hits; both are dropped
        applyStimulus(1'b1, 1'b0, 4'd8, 1'b0);
        en = 1'b1; dn = 1'b0;
        stepCycle();
        init = 1'b1;
        expPulses -= expQ.size();
        expQ.delete();
        stepCycle();
        checkOutput("init_sum", 32'(sum), 32'd0);
        checkOutput("init_cout", 32'(cout), 32'd0);
        checkOutput("init_value", 32'(value), 32'(INIT));
        checkOutput("init_wave_done", 32'(wave_done), 32'd0);
        init  = 1'b0;
        waveK = 0;

        applyStimulus(1'b1, 1'b0, 4'd6, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd7, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd8, 1'b0);
        holdCycles(3);
        applyStimulus(1'b1, 1'b0, 4'd9, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd9, 1'b0);
        en = 1'b0;
        repeat (3) stepCycle();

        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        checkOutput("wave_done_count", 32'(wdPulses), 32'(expPulses));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dr_digit_counter_n.md
# dr_digit_counter_n

Clocked, parametrised dual-rail up/down counter with digit-level wavefront pipelining. It generalises the fixed 32-digit NCL incrementer in three ways: width is a parameter, direction is selectable per wavefront, and the whole pipeline can be stalled. Each binary digit is a stage that alternates DATA and NULL wavefronts, with the carry/borrow moving one digit per clock. It sits where the NCL sandbox counters feed dual-rail consumers that need a cycle-accurate, synthesizable reference.

## Interface
- WIDTH, 32: number of binary digits (stages); minimum 2.
- INIT_VALUE, 0: binary value loaded into the digit state on reset; WIDTH bits.
- clk  in  1  single clock; all state updates on the rising edge.
- init  in  1  reset, synchronous, active-high.
- en  in  1  sampled on injection cycles: 1 injects carry DATA1 (count), 0 injects DATA0 (no change).
- dn  in  1  sampled on injection cycles: 0 counts up, 1 counts down; the tag travels with the wavefront.
- hold  in  1  global stall: every register keeps its value for the cycle.
- sum  out  2*WIDTH  dual-rail digit outputs; sum[2i+1] is the true rail and sum[2i] the false rail of digit i.
- sum_comp  out  WIDTH  per-digit completeness, OR of both rails (1 = DATA, 0 = NULL).
- cout  out  2  dual-rail carry/borrow out of digit WIDTH-1.
- wave_done  out  1  one-cycle pulse: a DATA wavefront has just completed at digit WIDTH-1.
- value  out  WIDTH  internal binary digit state, skewed: bit i reflects the wavefronts digit i has absorbed.

## Operation
- Encoding: NULL=00, DATA0=01 (false rail), DATA1=10 (true rail). 11 is never produced.
- Injector: a phase register p resets to 0 and toggles on every non-hold cycle.
  - When p=0: carry[0] = en ? DATA1 : DATA0, and the injected tag equals dn.
  - When p=1: carry[0] = NULL.
- Digit stage i, on a non-hold edge, acts on its incoming carry[i] and tag:
  - DATA carry c, up: sum <= dual-rail(v^c); carry[i+1] <= dual-rail(v&c); v <= v^c.
  - DATA carry c, down: sum <= dual-rail(v^c); borrow carry[i+1] <= dual-rail(~v&c); v <= v^c.
  - NULL carry: sum <= NULL; carry[i+1] <= NULL; v unchanged.
  - The tag is registered alongside carry[i+1].
- cout = carry[WIDTH].
- wave_done is registered and pulses 1 cycle after cout becomes DATA.
- Wrap-around: up from 2^WIDTH-1 gives all-zero digits and cout=DATA1. Down from 0 gives all-one digits and cout=DATA1. Otherwise cout=DATA0.
- en=0 wavefronts still propagate DATA0 through every digit and pulse wave_done; v is unchanged.
- Mixed directions in flight are legal. Each wavefront applies its own tag, and results equal sequential application.
- Reset:
  - v = INIT_VALUE, all sum and carry registers = NULL, all tags = 0, p = 0.
  - wave_done = 0, sum_comp = 0, cout = 00.
- init asserted mid-operation discards all in-flight wavefronts on that edge, with no partial update.
- hold and init together: init wins.

## Timing
- Edge 0 is the first rising edge with init=0; carry[0] is DATA during the cycle before edge 0.
- Wavefront k (counting non-hold cycles, k ≥ 0):
  - injected during the cycle preceding edge 2k;
  - digit i holds DATA after edge 2k+i and NULL after edge 2k+i+1;
  - cout holds DATA after edge 2k+WIDTH-1;
  - wave_done is high after edge 2k+WIDTH.
- Throughput is one wavefront per 2 cycles; latency to the top digit is WIDTH cycles.
- Each hold cycle shifts all later edges by one and changes nothing else.
- Consumers sample digit i only while sum_comp[i]=1.
- Adjacent digits are never simultaneously DATA for the same wavefront.

## Structure
- Package dr_pkg holds the NULL, DATA0 and DATA1 localparams and the dual-rail encode/decode functions. The other NCL-sandbox blocks share it.
- Sub-module dr_count_digit: one stage (v, sum, carry-out, tag registers), instantiated WIDTH times in a generate loop.
- The top level holds only the injector, the stage chain and the wave_done register.

## Test plan
- WIDTH=4, INIT=0, en=1, dn=0, 16 wavefronts:
  - after each wavefront the decoded digits read 1,2,…,15,0;
  - cout=DATA1 only on wavefront 15;
  - wave_done pulses 16 times, 2 cycles apart.
- WIDTH=4, INIT=0, dn=1, one wavefront: digits read 1111, cout=DATA1. A second wavefront reads 1110 with cout=DATA0.
- en=0 for 3 wavefronts from INIT=5: value stays 0101, sum shows DATA 0101 per digit, and wave_done still pulses.
- hold asserted for 3 cycles while wavefront 2 sits at digit 1: all outputs are frozen, and the completion edges shift by exactly 3.
- init pulsed while 2 wavefronts are in flight: the next cycle shows all sum=00, cout=00, value=INIT_VALUE; counting restarts with edge-0 timing.
- Alternating dn every wavefront from 7 (WIDTH=4): values read 8,7,8,7, with no interference between in-flight wavefronts.
